// File: rtl/bcd_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_scan
// Description : Binary-to-BCD converter (sequential double-dabble) feeding a
//               time-multiplexed, active-low, multi-digit 7-segment driver
//               with leading-zero blanking and overflow (dash) indication.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scan #(
    parameter int DIGITS   = 4,
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BIN_W-1:0]  bin,
    input  logic              blank_lz,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [0:6]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int c_cnt_w  = $clog2(BIN_W);
    localparam int c_idx_w  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_scan_w = $clog2(SCAN_DIV);
    localparam int c_bcd_w  = 4 * DIGITS;

    localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(BIN_W - 1);
    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(DIGITS - 1);
    localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_DIV - 1);

    localparam logic [1:0] c_s_idle   = 2'd0;
    localparam logic [1:0] c_s_conv   = 2'd1;
    localparam logic [1:0] c_s_commit = 2'd2;

    function automatic logic [31:0] f_pow10(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int k = 0; k < n; k++) begin
            p = p * 32'd10;
        end
        return p;
    endfunction

    // Largest value representable on the display (10^DIGITS - 1)
    localparam logic [31:0] c_max_val = f_pow10(DIGITS) - 32'd1;

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic [BIN_W-1:0]    r_bin;
    logic [c_bcd_w-1:0]  r_bcd;
    logic [c_bcd_w-1:0]  w_adj;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_blz;
    logic                r_ovf_cap;
    logic                w_ovf;
    logic                w_accept;
    logic [DIGITS-1:0]   w_blank;
    logic                w_run;
    logic [c_bcd_w-1:0]  r_disp;
    logic [DIGITS-1:0]   r_mask;
    logic                r_ovf;
    logic [c_scan_w-1:0] r_scan_cnt;
    logic [c_idx_w-1:0]  r_idx;
    logic [3:0]          w_nib;
    logic                w_dig_blank;
    logic [0:6]          w_seg;
    logic [DIGITS-1:0]   w_an;

    assign w_accept = (r_state == c_s_idle) && start;

    // Zero-extend both sides so any BIN_W compares cleanly against the limit
    assign w_ovf = ({32'd0, bin} > {{BIN_W{1'b0}}, c_max_val});

    // Add-3 correction on every BCD nibble that would overflow when doubled
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ?
                                 (r_bcd[4*g +: 4] + 4'd3) : r_bcd[4*g +: 4];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state and status outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            c_s_idle: begin
                if (start) begin
                    w_next = c_s_conv;
                end
            end
            c_s_conv: begin
                busy = 1'b1;
                if (r_cnt == c_cnt_last) begin
                    w_next = c_s_commit;
                end
            end
            c_s_commit: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = c_s_idle;
            end
            default: begin
                w_next = c_s_idle;
            end
        endcase
    end

    // Conversion datapath: capture on accepted start, shift-add-3 during CONV
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_blz     <= 1'b0;
            r_ovf_cap <= 1'b0;
        end else if (w_accept) begin
            r_bin     <= bin;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_blz     <= blank_lz;
            r_ovf_cap <= w_ovf;
        end else if (r_state == c_s_conv) begin
            // Bits shifted out of the top digit only matter on overflow,
            // where the digits are replaced by dashes anyway
            {r_bcd, r_bin} <= {w_adj[c_bcd_w-2:0], r_bin, 1'b0};
            r_cnt          <= r_cnt + c_cnt_w'(1);
        end
    end

    // Blank mask: a digit is blank when it and every digit above it are zero
    always_comb begin
        w_blank = '0;
        w_run   = r_blz;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_run      = w_run & (r_bcd[4*i +: 4] == 4'd0);
            w_blank[i] = w_run;
        end
    end

    // Display registers: only updated on COMMIT, reset to all-blank
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp <= '0;
            r_mask <= '1;
            r_ovf  <= 1'b0;
        end else if (r_state == c_s_commit) begin
            r_disp <= r_bcd;
            r_mask <= w_blank;
            r_ovf  <= r_ovf_cap;
        end
    end

    assign overflow = r_ovf;

    // Free-running scan divider and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == c_scan_last) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == c_idx_last) ? '0 : (r_idx + c_idx_w'(1));
        end else begin
            r_scan_cnt <= r_scan_cnt + c_scan_w'(1);
        end
    end

    // Select the current digit and decode it to segments / enables
    always_comb begin
        w_nib       = 4'd0;
        w_dig_blank = 1'b1;
        w_an        = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_nib       = r_disp[4*i +: 4];
                w_dig_blank = r_mask[i];
                w_an[i]     = 1'b0;
            end
        end
        if (r_ovf) begin
            w_seg = 7'b1111110;
        end else if (w_dig_blank) begin
            w_seg = 7'b1111111;
        end else begin
            case (w_nib)
                4'd0:    w_seg = 7'b0000001;
                4'd1:    w_seg = 7'b1001111;
                4'd2:    w_seg = 7'b0010010;
                4'd3:    w_seg = 7'b0000110;
                4'd4:    w_seg = 7'b1001100;
                4'd5:    w_seg = 7'b0100100;
                4'd6:    w_seg = 7'b0100000;
                4'd7:    w_seg = 7'b0001111;
                4'd8:    w_seg = 7'b0000000;
                4'd9:    w_seg = 7'b0000100;
                default: w_seg = 7'b1111111;
            endcase
        end
    end

    // Register seg and an together so they always refer to the same digit
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= 7'b1111111;
            an  <= '1;
        end else begin
            seg <= w_seg;
            an  <= w_an;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_display_scan
// Description : Directed self-checking bench for bcd_display_scan
//               (DIGITS=4, BIN_W=14, SCAN_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scan;

    localparam logic [6:0] c_blk  = 7'b1111111;
    localparam logic [6:0] c_dash = 7'b1111110;
    localparam logic [6:0] c_d0   = 7'b0000001;
    localparam logic [6:0] c_d1   = 7'b1001111;
    localparam logic [6:0] c_d2   = 7'b0010010;
    localparam logic [6:0] c_d3   = 7'b0000110;
    localparam logic [6:0] c_d4   = 7'b1001100;
    localparam logic [6:0] c_d7   = 7'b0001111;
    localparam logic [6:0] c_d9   = 7'b0000100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic        blank_lz = 1'b0;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [0:6]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    bcd_display_scan #(
        .DIGITS   (4),
        .BIN_W    (14),
        .SCAN_DIV (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    // Launch a conversion and wait for done; lat counts cycles after T0
    task automatic run_conversion(input logic [13:0] b, input logic blz,
                                  output int lat, output bit tmo);
        @(negedge clk);
        bin      = b;
        blank_lz = blz;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        tmo = !done;
    endtask

    // Gather the segment pattern shown for each digit; packed {d3,d2,d1,d0}
    task automatic capture_display(output logic [27:0] segs, output bit ok);
        logic [3:0] seen;
        seen = 4'h0;
        segs = '1;
        ok   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 32 && seen != 4'hF; c++) begin
            @(negedge clk);
            case (an)
                4'b1110: begin segs[6:0]   = seg; seen[0] = 1'b1; end
                4'b1101: begin segs[13:7]  = seg; seen[1] = 1'b1; end
                4'b1011: begin segs[20:14] = seg; seen[2] = 1'b1; end
                4'b0111: begin segs[27:21] = seg; seen[3] = 1'b1; end
                default: ok = 1'b0;
            endcase
        end
        if (seen != 4'hF) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got=%b exp=1111", an); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL post_reset_an got=%b exp=1110", an); end
        checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL post_reset_seg got=%b exp=1111111", seg); end
    endtask

    task automatic test_convert_1234();
        int lat; bit tmo; bit ok; int dur; int g;
        logic [27:0] segs;
        run_conversion(14'd1234, 1'b0, lat, tmo);
        checks++; if (tmo || lat != 15) begin errors++; $display("FAIL done_latency got=%0d exp=15 timeout=%0d", lat, tmo); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_commit got=%b exp=1", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_pulse_end got done=%b busy=%b exp 0 0", done, busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_1234 got=%b exp=0", overflow); end
        capture_display(segs, ok);
        checks++; if (!ok || segs !== {c_d1, c_d2, c_d3, c_d4}) begin errors++; $display("FAIL disp_1234 got=%h exp=%h ok=%0d", segs, {c_d1, c_d2, c_d3, c_d4}, ok); end
        // Digit-0 dwell time and the digit that follows it
        g = 0;
        while (an !== 4'b1101 && g < 40) begin @(negedge clk); g++; end
        while (an !== 4'b1110 && g < 40) begin @(negedge clk); g++; end
        dur = 0;
        while (an === 4'b1110 && g < 40) begin @(negedge clk); g++; dur++; end
        checks++; if (dur != 4) begin errors++; $display("FAIL digit_dwell got=%0d exp=4", dur); end
        checks++; if (an !== 4'b1101) begin errors++; $display("FAIL scan_order got=%b exp=1101", an); end
    endtask

    task automatic test_blanking();
        int lat; bit tmo; bit ok;
        logic [27:0] segs;
        run_conversion(14'd7, 1'b1, lat, tmo);
        capture_display(segs, ok);
        checks++; if (tmo || !ok || segs !== {c_blk, c_blk, c_blk, c_d7}) begin errors++; $display("FAIL blank_7 got=%h exp=%h", segs, {c_blk, c_blk, c_blk, c_d7}); end
        run_conversion(14'd0, 1'b1, lat, tmo);
        capture_display(segs, ok);
        checks++; if (tmo || !ok || segs !== {c_blk, c_blk, c_blk, c_d0}) begin errors++; $display("FAIL blank_0 got=%h exp=%h", segs, {c_blk, c_blk, c_blk, c_d0}); end
        run_conversion(14'd40, 1'b1, lat, tmo);
        capture_display(segs, ok);
        checks++; if (tmo || !ok || segs !== {c_blk, c_blk, c_d4, c_d0}) begin errors++; $display("FAIL blank_40 got=%h exp=%h", segs, {c_blk, c_blk, c_d4, c_d0}); end
    endtask

    task automatic test_overflow();
        int lat; bit tmo; bit ok;
        logic [27:0] segs;
        run_conversion(14'd10000, 1'b0, lat, tmo);
        capture_display(segs, ok);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_10000 got=%b exp=1", overflow); end
        checks++; if (tmo || !ok || segs !== {4{c_dash}}) begin errors++; $display("FAIL disp_10000 got=%h exp=%h", segs, {4{c_dash}}); end
        run_conversion(14'd9999, 1'b0, lat, tmo);
        capture_display(segs, ok);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_9999 got=%b exp=0", overflow); end
        checks++; if (tmo || !ok || segs !== {4{c_d9}}) begin errors++; $display("FAIL disp_9999 got=%h exp=%h", segs, {4{c_d9}}); end
    endtask

    task automatic test_start_while_busy();
        int dones; bit ok;
        logic [27:0] segs;
        @(negedge clk);
        bin = 14'd1234; blank_lz = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int n = 1; n <= 30; n++) begin
            if (done) dones++;
            if (n == 5) begin bin = 14'd5678; start = 1'b1; end
            if (n == 6) start = 1'b0;
            @(negedge clk);
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL busy_start_dones got=%0d exp=1", dones); end
        capture_display(segs, ok);
        checks++; if (!ok || segs !== {c_d1, c_d2, c_d3, c_d4}) begin errors++; $display("FAIL busy_start_disp got=%h exp=%h", segs, {c_d1, c_d2, c_d3, c_d4}); end
    endtask

    task automatic test_reset_abort();
        int dones; bit ok;
        logic [27:0] segs;
        @(negedge clk);
        bin = 14'd9999; blank_lz = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int n = 1; n <= 30; n++) begin
            if (done) dones++;
            if (n == 8) rst = 1'b1;
            if (n == 9) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
                rst = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL abort_dones got=%0d exp=0", dones); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL abort_ovf got=%b exp=0", overflow); end
        capture_display(segs, ok);
        checks++; if (!ok || segs !== {4{c_blk}}) begin errors++; $display("FAIL abort_disp got=%h exp=%h", segs, {4{c_blk}}); end
    endtask

    initial begin
        test_reset();
        test_convert_1234();
        test_blanking();
        test_overflow();
        test_start_while_busy();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
